fft_frame_feeder: RTL

Sits between the asynchronous sample FIFO read side and the FFT core sink, all in the MCLK domain. It pulls audio samples from the FIFO into a circular frame buffer. It then emits complete FFT_SIZE-sample frames on a streaming interface with sop/eop framing and full ready/valid backpressure. Frames can overlap by 0%, 50% or 75%, selected at run time, which gives better time resolution for the LED spectrum display.

---
 rtl/fft_feeder_pkg.sv | 25 ++
 rtl/frame_buffer_ram.sv | 30 +++
 rtl/fft_frame_feeder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fft_feeder_pkg.sv
// rtl/fft_feeder_pkg.sv - shared hop codes, state encoding and hop length helper for the FFT frame feeder
package fft_feeder_pkg;

    localparam logic [1:0] HOP_FULL    = 2'd0;
    localparam logic [1:0] HOP_HALF    = 2'd1;
    localparam logic [1:0] HOP_QUARTER = 2'd2;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } feeder_state_t;

    // Code 3 is unassigned and falls back to a full-frame hop.
    function automatic logic [31:0] hop_len(input logic [1:0] code, input int size_width);
        logic [31:0] n;
        n = 32'd1 << size_width;
        case (code)
            HOP_FULL:    return n;
            HOP_HALF:    return n >> 1;
            HOP_QUARTER: return n >> 2;
            default:     return n;
        endcase
    endfunction

endpackage

// File: rtl/frame_buffer_ram.sv
// rtl/frame_buffer_ram.sv - simple dual-port frame buffer, one write port and one registered read port
module frame_buffer_ram #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // No reset on the array or read register so the tools can map this onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - pulls FIFO samples into a circular buffer and streams overlapping FFT frames
module fft_frame_feeder
    import fft_feeder_pkg::*;
#(
    parameter int SAMPLE_WIDTH    = 24,
    parameter int FFT_SIZE_WIDTH  = 10,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       MCLK,
    input  logic                       reset,
    input  logic [1:0]                 hop_sel,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic [SAMPLE_WIDTH-1:0]    fifo_data,
    input  logic                       src_ready,
    output logic                       src_valid,
    output logic                       src_sop,
    output logic                       src_eop,
    output logic [SAMPLE_WIDTH-1:0]    src_real,
    output logic [SAMPLE_WIDTH-1:0]    src_imag,
    output logic                       busy,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam logic [FFT_SIZE_WIDTH:0] C_N    = {1'b1, {FFT_SIZE_WIDTH{1'b0}}};
    localparam logic [FFT_SIZE_WIDTH:0] C_LAST = {1'b0, {FFT_SIZE_WIDTH{1'b1}}};

    feeder_state_t               r_state;
    logic [1:0]                  r_hop_code;
    logic [FFT_SIZE_WIDTH-1:0]   r_wr_ptr;
    logic [FFT_SIZE_WIDTH:0]     r_fill_cnt;
    logic [FFT_SIZE_WIDTH:0]     r_new_cnt;
    logic [FFT_SIZE_WIDTH-1:0]   r_rd_ptr;
    logic [FFT_SIZE_WIDTH:0]     r_issue_k;
    logic                        r_inflight;
    logic                        r_busy;
    logic [FRAME_CNT_WIDTH-1:0]  r_frame_count;

    logic                        r_q_valid;
    logic                        r_q_sop;
    logic                        r_q_eop;
    logic                        r_out_valid;
    logic                        r_out_sop;
    logic                        r_out_eop;
    logic [SAMPLE_WIDTH-1:0]     r_out_data;
    logic                        r_skid_valid;
    logic                        r_skid_sop;
    logic                        r_skid_eop;
    logic [SAMPLE_WIDTH-1:0]     r_skid_data;

    logic [31:0]                 w_hop_len;
    logic                        w_enough;
    logic                        w_go_emit;
    logic                        w_rd_en;
    logic                        w_pop;
    logic [1:0]                  w_occ;
    logic                        w_issue;
    logic [FFT_SIZE_WIDTH-1:0]   w_rd_addr;
    logic [SAMPLE_WIDTH-1:0]     w_ram_rdata;
    logic                        w_wr_en;

    assign w_hop_len = hop_len(r_hop_code, FFT_SIZE_WIDTH);
    assign w_enough  = (r_fill_cnt == C_N) && (32'(r_new_cnt) >= w_hop_len);
    assign w_go_emit = (r_state == FILL) && w_enough && !r_inflight;

    // Combinational strobe so a read is never issued against a FIFO that just went empty.
    assign w_rd_en   = !reset && (r_state == FILL) && !fifo_empty && !r_inflight && !w_enough;
    assign w_wr_en   = r_inflight && !reset;

    assign w_pop     = r_out_valid && src_ready;
    // Occupancy after this cycle's pop; a new read is launched only if its data is sure of a slot.
    assign w_occ     = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_q_valid) - 2'(w_pop);
    assign w_issue   = (r_state == EMIT) && (r_issue_k != C_N) && (w_occ < 2'd2);
    assign w_rd_addr = r_rd_ptr + r_issue_k[FFT_SIZE_WIDTH-1:0];

    frame_buffer_ram #(
        .DATA_WIDTH (SAMPLE_WIDTH),
        .ADDR_WIDTH (FFT_SIZE_WIDTH)
    ) u_ram (
        .i_clk     (MCLK),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (fifo_data),
        .i_rd_en   (w_issue),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_rdata)
    );

    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_state       <= FILL;
            r_hop_code    <= hop_sel;
            r_wr_ptr      <= '0;
            r_fill_cnt    <= '0;
            r_new_cnt     <= '0;
            r_rd_ptr      <= '0;
            r_issue_k     <= '0;
            r_inflight    <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_inflight <= w_rd_en;
            if (r_inflight) begin
                r_wr_ptr  <= r_wr_ptr + 1'b1;
                r_new_cnt <= r_new_cnt + 1'b1;
                if (r_fill_cnt != C_N) begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                end
            end
            if (w_issue) begin
                r_issue_k <= r_issue_k + 1'b1;
            end
            case (r_state)
                FILL: begin
                    // The write pointer now addresses the oldest of the last N samples.
                    if (w_go_emit) begin
                        r_state   <= EMIT;
                        r_rd_ptr  <= r_wr_ptr;
                        r_new_cnt <= '0;
                        r_issue_k <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                EMIT: begin
                    if (w_pop && r_out_eop) begin
                        r_state       <= FILL;
                        r_busy        <= 1'b0;
                        r_frame_count <= r_frame_count + 1'b1;
                        r_hop_code    <= hop_sel;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_q_valid    <= 1'b0;
            r_q_sop      <= 1'b0;
            r_q_eop      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_sop    <= 1'b0;
            r_out_eop    <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_sop   <= 1'b0;
            r_skid_eop   <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            r_q_valid <= w_issue;
            r_q_sop   <= w_issue && (r_issue_k == '0);
            r_q_eop   <= w_issue && (r_issue_k == C_LAST);
            if (!r_out_valid || w_pop) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_sop    <= r_skid_sop;
                    r_out_eop    <= r_skid_eop;
                    r_out_data   <= r_skid_data;
                    r_skid_valid <= r_q_valid;
                    r_skid_sop   <= r_q_sop;
                    r_skid_eop   <= r_q_eop;
                    r_skid_data  <= w_ram_rdata;
                end else if (r_q_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_sop    <= r_q_sop;
                    r_out_eop    <= r_q_eop;
                    r_out_data   <= w_ram_rdata;
                end else begin
                    r_out_valid  <= 1'b0;
                    r_out_sop    <= 1'b0;
                    r_out_eop    <= 1'b0;
                end
            end else if (r_q_valid) begin
                r_skid_valid <= 1'b1;
                r_skid_sop   <= r_q_sop;
                r_skid_eop   <= r_q_eop;
                r_skid_data  <= w_ram_rdata;
            end
        end
    end

    assign fifo_rd_en  = w_rd_en;
    assign src_valid   = r_out_valid;
    assign src_sop     = r_out_sop;
    assign src_eop     = r_out_eop;
    assign src_real    = r_out_data;
    assign src_imag    = '0;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;

endmodule
